sram_s2mm_fifo_ctrl: RTL

Stream sequencer that turns the 16x8 one-write/one-read `sram_s2mm` macro into a ready/valid FIFO between the stream-to-memory-mapped (S2MM) input path and the systolic-array operand feeder. It owns both SRAM ports, tracks occupancy, prevents same-address read/write collisions, and hides the SRAM's one-cycle read latency behind a 2-entry output buffer so the output streams one word per cycle under no backpressure.

---
 rtl/sram_s2mm_fifo_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sram_s2mm_fifo_ctrl.sv
// Ready/valid FIFO built around the 16x8 one-write/one-read sram_s2mm macro.
// A 2-entry output buffer hides the SRAM read latency so the output can stream one word per cycle.
module sram_s2mm_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   mem_count,
    output logic                  empty,
    output logic                  full,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  rd_inflight;
    logic [1:0]            obuf_count;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            credit;

    // A read may only be issued if its data will have a free obuf slot on arrival,
    // counting the word already in flight and the slot freed by this cycle's pop.
    always_comb begin
        s_ready = rst_n && !flush && (mem_count < FULL_COUNT);
        push    = s_valid && s_ready;
        m_valid = (obuf_count != 2'd0);
        pop     = m_valid && m_ready;
        credit  = {1'b0, obuf_count} + {2'b0, rd_inflight} - {2'b0, pop};
        issue   = rst_n && !flush && (mem_count != '0) && (credit < 3'd2);
    end

    assign m_data     = obuf[0];
    assign empty      = (mem_count == '0) && !rd_inflight && (obuf_count == 2'd0);
    assign full       = (mem_count == FULL_COUNT);
    assign sram_csb0  = !push;
    assign sram_addr0 = wptr;
    assign sram_din0  = s_data;
    assign sram_csb1  = !issue;
    assign sram_addr1 = rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_count   <= '0;
            rd_inflight <= 1'b0;
            obuf_count  <= 2'd0;
            obuf[0]     <= '0;
            obuf[1]     <= '0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_count   <= '0;
            rd_inflight <= 1'b0;
            obuf_count  <= 2'd0;
        end else begin
            if (push)
                wptr <= wptr + ADDR_WIDTH'(1);
            if (issue)
                rptr <= rptr + ADDR_WIDTH'(1);
            rd_inflight <= issue;
            if (push && !issue)
                mem_count <= mem_count + (ADDR_WIDTH+1)'(1);
            else if (issue && !push)
                mem_count <= mem_count - (ADDR_WIDTH+1)'(1);

            // Returning read data lands at the tail; a same-cycle pop shifts the head out.
            case ({rd_inflight, pop})
                2'b01: begin
                    obuf[0]    <= obuf[1];
                    obuf_count <= obuf_count - 2'd1;
                end
                2'b10: begin
                    if (obuf_count == 2'd0)
                        obuf[0] <= sram_dout1;
                    else
                        obuf[1] <= sram_dout1;
                    obuf_count <= obuf_count + 2'd1;
                end
                2'b11: begin
                    if (obuf_count == 2'd1) begin
                        obuf[0] <= sram_dout1;
                    end else begin
                        obuf[0] <= obuf[1];
                        obuf[1] <= sram_dout1;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));

    a_no_obuf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_inflight && !pop && (obuf_count == 2'd2)));

endmodule
